// File: rtl/nco_pkg.sv
// Shared defaults, dither LFSR constants and handshake state type for the NCO tone generator.
package nco_pkg;

    localparam int unsigned DEF_PHASE_W = 16;
    localparam int unsigned DEF_LUT_AW  = 6;
    localparam int unsigned DEF_AMP     = 127;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        IDLE,
        PENDING
    } freq_state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        return {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/nco_sine_lut.sv
// Quarter-wave sine ROM, contents computed at elaboration; registered, optionally negated output.
module nco_sine_lut
    import nco_pkg::*;
#(
    parameter int unsigned LUT_AW = DEF_LUT_AW,
    parameter int unsigned AMP    = DEF_AMP
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_en,
    input  logic [LUT_AW-1:0] i_addr,
    input  logic              i_neg,
    output logic signed [7:0] o_data
);

    localparam int unsigned DEPTH   = 2 ** LUT_AW;
    localparam real         HALF_PI = 1.5707963267948966;

    logic [6:0] rom_mag [DEPTH];
    logic [6:0] mag;

    // Round-half-up is exact here since every entry is non-negative
    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam real ANGLE = HALF_PI * real'(k) / real'(DEPTH);
        assign rom_mag[k] = 7'($rtoi(real'(AMP) * $sin(ANGLE) + 0.5));
    end

    assign mag = rom_mag[i_addr];

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_data <= '0;
        end else if (i_en) begin
            o_data <= i_neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
        end
    end

endmodule

// File: rtl/nco_tone_gen.sv
// NCO: phase accumulator, wrap-synchronous frequency update handshake, quarter-wave sine output.
// Define NCO_DITHER_EN to add LFSR phase dither ahead of LUT indexing.
module nco_tone_gen
    import nco_pkg::*;
#(
    parameter int unsigned PHASE_W = DEF_PHASE_W,
    parameter int unsigned LUT_AW  = DEF_LUT_AW,
    parameter int unsigned AMP     = DEF_AMP
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_enable,
    input  logic [PHASE_W-1:0] i_freq_word,
    input  logic               i_freq_valid,
    output logic               o_freq_ready,
    output logic signed [7:0]  o_data,
    output logic               o_valid,
    output logic               o_wrap
);

    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] freq_q;
    logic [PHASE_W-1:0] pending_q;
    logic [PHASE_W-1:0] lut_phase;
    logic [PHASE_W:0]   sum;
    logic               acc_wrap_q;
    logic               ready_q;
    freq_state_e        state_q;

    logic [1:0]         quad_q;
    logic [LUT_AW-1:0]  addr_q;
    logic [LUT_AW-1:0]  lut_addr;
    logic               s1_wrap_q;
    logic               s1_valid_q;
    logic               unused_lsb;

    assign sum          = {1'b0, phase_q} + {1'b0, freq_q};
    assign o_freq_ready = ready_q;

`ifdef NCO_DITHER_EN
    localparam int unsigned DITHER_W = PHASE_W - LUT_AW - 2;

    logic [15:0] lfsr_q;
    logic        unused_lfsr;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (i_enable) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    // Dither only perturbs the LUT index; the accumulator stays exact
    assign lut_phase   = phase_q + PHASE_W'(lfsr_q[DITHER_W-1:0]);
    assign unused_lfsr = ^lfsr_q[15:DITHER_W];
`else
    assign lut_phase = phase_q;
`endif

    assign unused_lsb = ^lut_phase[PHASE_W-LUT_AW-3:0];

    // Accumulator and frequency handshake
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            phase_q    <= '0;
            acc_wrap_q <= 1'b0;
            freq_q     <= '0;
            pending_q  <= '0;
            state_q    <= IDLE;
            ready_q    <= 1'b1;
        end else begin
            if (i_enable) begin
                phase_q    <= sum[PHASE_W-1:0];
                acc_wrap_q <= sum[PHASE_W];
            end
            case (state_q)
                IDLE: begin
                    if (i_freq_valid) begin
                        pending_q <= i_freq_word;
                        state_q   <= PENDING;
                        ready_q   <= 1'b0;
                    end
                end
                PENDING: begin
                    // A zero step never wraps, so apply immediately in that case
                    if (freq_q == '0 || (i_enable && sum[PHASE_W])) begin
                        freq_q  <= pending_q;
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            quad_q     <= '0;
            addr_q     <= '0;
            s1_wrap_q  <= 1'b0;
            s1_valid_q <= 1'b0;
            o_valid    <= 1'b0;
            o_wrap     <= 1'b0;
        end else begin
            s1_valid_q <= i_enable;
            if (i_enable) begin
                quad_q    <= lut_phase[PHASE_W-1 -: 2];
                addr_q    <= lut_phase[PHASE_W-3 -: LUT_AW];
                s1_wrap_q <= acc_wrap_q;
            end
            o_valid <= s1_valid_q;
            o_wrap  <= s1_valid_q & s1_wrap_q;
        end
    end

    // Odd quadrants walk the quarter wave backwards: ~addr == 2**LUT_AW-1-addr
    assign lut_addr = quad_q[0] ? ~addr_q : addr_q;

    nco_sine_lut #(
        .LUT_AW (LUT_AW),
        .AMP    (AMP)
    ) u_lut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_en      (s1_valid_q),
        .i_addr    (lut_addr),
        .i_neg     (quad_q[1]),
        .o_data    (o_data)
    );

endmodule

// File: tb/tb_nco_tone_gen.sv
// Directed bench for nco_tone_gen at default parameters, dither disabled.
module tb_nco_tone_gen;

    logic        i_clk        = 1'b0;
    logic        i_reset_n    = 1'b0;
    logic        i_enable     = 1'b0;
    logic [15:0] i_freq_word  = '0;
    logic        i_freq_valid = 1'b0;
    logic        o_freq_ready;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        o_wrap;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        rec_en   = 1'b0;
    logic [8:0]  samples [$];
    logic [8:0]  exp_q [$];

    // LUT values by hand for phase = k*16'h1000, k = 0..15
    int t3_data [25] = '{0, 49, 90, 117, 127, 116, 88, 46,
                         0, -49, -90, -117, -127, -116, -88, -46,
                         0, 90, 127, 88, 0, -90, -127, -88, 0};
    int quad_pat [4] = '{0, 127, 0, -127};
    int t4_data  [5] = '{0, 25, 49, 71, 90};

    always #5 i_clk = ~i_clk;

    nco_tone_gen dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_enable     (i_enable),
        .i_freq_word  (i_freq_word),
        .i_freq_valid (i_freq_valid),
        .o_freq_ready (o_freq_ready),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_wrap       (o_wrap)
    );

    always @(negedge i_clk) begin
        if (rec_en && o_valid) samples.push_back({o_wrap, o_data});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [8:0] smp(input logic w, input int d);
        return {w, d[7:0]};
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic step_n(input int n);
        repeat (n) step();
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_count"}, 32'(samples.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            check($sformatf("%s[%0d]", tag, i),
                  (i < samples.size()) ? 32'(samples[i]) : 32'hDEAD, 32'(exp_q[i]));
        end
    endtask

    // Offer a word while freq==0: captured on the first edge, applied on the next
    task automatic load_word(input logic [15:0] w, input string tag);
        i_freq_word  = w;
        i_freq_valid = 1'b1;
        step();
        i_freq_valid = 1'b0;
        @(negedge i_clk);
        check({tag, "_ready_cap"}, 32'(o_freq_ready), 32'd0);
        step();
        @(negedge i_clk);
        check({tag, "_ready_apply"}, 32'(o_freq_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        i_reset_n = 1'b0;
        step_n(3);
        @(negedge i_clk);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_wrap", 32'(o_wrap), 32'd0);
        check("rst_ready", 32'(o_freq_ready), 32'd1);

        // Quarter-rate tone with a 5-cycle enable gap
        i_reset_n = 1'b1;
        load_word(16'h4000, "t2");
        samples.delete();
        rec_en   = 1'b1;
        i_enable = 1'b1;
        step_n(10);
        i_enable = 1'b0;
        step();
        @(negedge i_clk);
        check("t5_valid_drain", 32'(o_valid), 32'd1);
        step();
        @(negedge i_clk);
        check("t5_valid_low", 32'(o_valid), 32'd0);
        check("t5_data_hold", 32'(o_data), 32'd127);
        step_n(3);
        @(negedge i_clk);
        check("t5_data_hold_end", 32'(o_data), 32'd127);
        i_enable = 1'b1;
        step_n(10);
        @(negedge i_clk);
        #1;
        exp_q.delete();
        for (int j = 0; j < 19; j++) exp_q.push_back(smp(j >= 4 && j % 4 == 0, quad_pat[j % 4]));
        check_stream("t2");

        // Update deferred to the phase wrap
        i_enable  = 1'b0;
        rec_en    = 1'b0;
        i_reset_n = 1'b0;
        step_n(2);
        i_reset_n = 1'b1;
        load_word(16'h1000, "t3");
        samples.delete();
        rec_en   = 1'b1;
        i_enable = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            step();
            if (k == 8) begin
                i_freq_word  = 16'h2000;
                i_freq_valid = 1'b1;
            end
            if (k == 9) begin
                i_freq_valid = 1'b0;
                @(negedge i_clk);
                check("t3_ready_cap", 32'(o_freq_ready), 32'd0);
            end
            if (k == 15) begin
                @(negedge i_clk);
                check("t3_ready_wait", 32'(o_freq_ready), 32'd0);
            end
            if (k == 16) begin
                @(negedge i_clk);
                check("t3_ready_after", 32'(o_freq_ready), 32'd1);
            end
        end
        @(negedge i_clk);
        #1;
        exp_q.delete();
        for (int j = 0; j < 25; j++) exp_q.push_back(smp(j == 16 || j == 24, t3_data[j]));
        check_stream("t3");

        // Reset while a word is pending
        i_freq_word  = 16'h3000;
        i_freq_valid = 1'b1;
        step();
        i_freq_valid = 1'b0;
        @(negedge i_clk);
        check("t6_ready_pend", 32'(o_freq_ready), 32'd0);
        i_reset_n = 1'b0;
        i_enable  = 1'b0;
        rec_en    = 1'b0;
        step_n(2);
        i_reset_n = 1'b1;
        @(negedge i_clk);
        check("t6_ready_rel", 32'(o_freq_ready), 32'd1);
        samples.delete();
        rec_en   = 1'b1;
        i_enable = 1'b1;
        step_n(6);
        @(negedge i_clk);
        #1;
        exp_q.delete();
        for (int j = 0; j < 5; j++) exp_q.push_back(smp(1'b0, 0));
        check_stream("t6");

        // Immediate apply from a zero step
        rec_en   = 1'b0;
        i_enable = 1'b0;
        step_n(3);
        load_word(16'h0800, "t4");
        samples.delete();
        rec_en   = 1'b1;
        i_enable = 1'b1;
        step_n(6);
        @(negedge i_clk);
        #1;
        exp_q.delete();
        for (int j = 0; j < 5; j++) exp_q.push_back(smp(1'b0, t4_data[j]));
        check_stream("t4");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
